// File: rtl/timer_apb_seq.sv
// APB master that sequences a simple timer peripheral: it loads and starts
// the timer, polls its status register for the direction-matching flag,
// clears each flag it sees, and stops the timer after the requested number
// of events.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// W_TDR    | write reload value to TDR
// W_LOAD   | write TCR with load bit set
// W_RUN    | write TCR with enable bit set
// GAP      | idle POLL_GAP cycles between status polls
// R_TSR    | read TSR, test the direction-matching flag
// W_CLR    | write-1-to-clear the matching flag, count the event
// W_STOP   | write TCR = 0x00
// DONE     | one-cycle done pulse
//
// Every transfer state runs SETUP -> ACCESS (until pready) -> POST. POST is
// the mandatory psel=0 cycle after a transfer; the next state is chosen there,
// so a read captured one cycle late is already visible when deciding.
module timer_apb_seq #(
  parameter int POLL_GAP      = 4,
  parameter int RD_SAMPLE_DLY = 1
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] cfg_data,
  input  logic       cfg_up_dw,
  input  logic [1:0] cfg_cks,
  input  logic [7:0] cfg_events,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic       pready,
  input  logic       pslverr,
  input  logic [7:0] prdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] event_cnt
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_W_TDR  = 4'd1;
  localparam logic [3:0] S_W_LOAD = 4'd2;
  localparam logic [3:0] S_W_RUN  = 4'd3;
  localparam logic [3:0] S_GAP    = 4'd4;
  localparam logic [3:0] S_R_TSR  = 4'd5;
  localparam logic [3:0] S_W_CLR  = 4'd6;
  localparam logic [3:0] S_W_STOP = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_ACCESS = 2'd1;
  localparam logic [1:0] PH_POST   = 2'd2;

  localparam logic [7:0] A_TDR = 8'h00;
  localparam logic [7:0] A_TCR = 8'h01;
  localparam logic [7:0] A_TSR = 8'h02;

  // GAP is a down-counter loaded with POLL_GAP-1 and left at terminal count 0
  localparam logic [7:0] GAP_LOAD = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
  localparam logic [3:0] S_POLL   = (POLL_GAP == 0) ? S_R_TSR : S_GAP;

  logic [3:0] state;
  logic [1:0] ph;
  logic       up_q;
  logic [1:0] cks_q;
  logic [7:0] data_q;
  logic [7:0] events_q;
  logic [7:0] cnt_q;
  logic [7:0] gap_q;
  logic [7:0] tsr_q;
  logic       err_q;
  logic       stop_pend;

  logic       in_xfer;
  logic       wr_c;
  logic [7:0] addr_c;
  logic [7:0] data_c;
  logic [7:0] clr_mask;
  logic [7:0] ev_target;
  logic [7:0] cnt_inc;
  logic [7:0] rd_byte;
  logic       flag_hit;
  logic       stop_ok;
  logic       abort;
  logic [3:0] post_next;

  assign clr_mask  = up_q ? 8'h01 : 8'h02;
  assign ev_target = (events_q == 8'd0) ? 8'd1 : events_q;
  assign cnt_inc   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
  assign rd_byte   = (RD_SAMPLE_DLY != 0) ? prdata : tsr_q;
  assign flag_hit  = |(rd_byte & clr_mask);
  assign stop_ok   = (state != S_IDLE) && (state != S_W_STOP) && (state != S_DONE);
  assign abort     = stop_ok && (stop || stop_pend);

  // Transfer address/data/direction for the current state
  always_comb begin
    in_xfer = 1'b1;
    wr_c    = 1'b1;
    addr_c  = 8'h00;
    data_c  = 8'h00;
    case (state)
      S_W_TDR:  data_c = data_q;
      S_W_LOAD: begin addr_c = A_TCR; data_c = {1'b1, 1'b0, up_q, 1'b0, 2'b00, cks_q}; end
      S_W_RUN:  begin addr_c = A_TCR; data_c = {2'b00, up_q, 1'b1, 2'b00, cks_q}; end
      S_R_TSR:  begin addr_c = A_TSR; wr_c = 1'b0; end
      S_W_CLR:  begin addr_c = A_TSR; data_c = clr_mask; end
      S_W_STOP: addr_c = A_TCR;
      default:  begin in_xfer = 1'b0; wr_c = 1'b0; end
    endcase
  end

  // Successor chosen in the POST cycle of a transfer; a pending stop overrides
  always_comb begin
    post_next = S_IDLE;
    case (state)
      S_W_TDR:  post_next = S_W_LOAD;
      S_W_LOAD: post_next = S_W_RUN;
      S_W_RUN:  post_next = S_POLL;
      S_R_TSR:  post_next = flag_hit ? S_W_CLR : S_POLL;
      S_W_CLR:  post_next = (cnt_inc == ev_target) ? S_W_STOP : S_POLL;
      S_W_STOP: post_next = stop_pend ? S_IDLE : S_DONE;
      default:  post_next = S_IDLE;
    endcase
    if (abort) post_next = S_W_STOP;
  end

  // Sequencer state, run configuration and counters
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= S_IDLE;
      ph        <= PH_SETUP;
      up_q      <= 1'b0;
      cks_q     <= 2'b00;
      data_q    <= 8'h00;
      events_q  <= 8'h00;
      cnt_q     <= 8'h00;
      gap_q     <= 8'h00;
      tsr_q     <= 8'h00;
      err_q     <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      if (stop && stop_ok) stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            up_q      <= cfg_up_dw;
            cks_q     <= cfg_cks;
            data_q    <= cfg_data;
            events_q  <= cfg_events;
            cnt_q     <= 8'h00;
            err_q     <= 1'b0;
            stop_pend <= 1'b0;
            ph        <= PH_SETUP;
            state     <= S_W_TDR;
          end
        end
        S_GAP: begin
          ph <= PH_SETUP;
          if (abort)               state <= S_W_STOP;
          else if (gap_q == 8'd0)  state <= S_R_TSR;
          else                     gap_q <= gap_q - 8'd1;
        end
        S_DONE: state <= S_IDLE;
        default: begin
          case (ph)
            PH_SETUP: ph <= PH_ACCESS;
            PH_ACCESS: begin
              if (pready) begin
                if (pslverr) begin
                  err_q <= 1'b1;
                  ph    <= PH_SETUP;
                  state <= S_IDLE;
                end else begin
                  tsr_q <= prdata;
                  ph    <= PH_POST;
                end
              end
            end
            default: begin
              ph    <= PH_SETUP;
              state <= post_next;
              if (post_next == S_GAP) gap_q <= GAP_LOAD;
              if (state == S_W_CLR)   cnt_q <= cnt_inc;
            end
          endcase
        end
      endcase
    end
  end

  assign psel      = in_xfer && (ph != PH_POST);
  assign penable   = in_xfer && (ph == PH_ACCESS);
  assign pwrite    = psel && wr_c;
  assign paddr     = psel ? addr_c : 8'h00;
  assign pwdata    = psel ? data_c : 8'h00;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign event_cnt = cnt_q;

endmodule

// File: tb/tb_timer_apb_seq.sv
// Bench for timer_apb_seq: a behavioural timer slave answers the APB bus, a
// monitor logs every completed transfer, and each run is compared with the
// transfer list the sequencing rules predict for its configuration.
module tb_timer_apb_seq;

  localparam int POLL_GAP = 4;

  logic       pclk;
  logic       preset_n;
  logic       start;
  logic       stop;
  logic [7:0] cfg_data;
  logic       cfg_up_dw;
  logic [1:0] cfg_cks;
  logic [7:0] cfg_events;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] prdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] event_cnt;

  timer_apb_seq #(.POLL_GAP(POLL_GAP), .RD_SAMPLE_DLY(1)) dut (
    .pclk(pclk), .preset_n(preset_n), .start(start), .stop(stop),
    .cfg_data(cfg_data), .cfg_up_dw(cfg_up_dw), .cfg_cks(cfg_cks),
    .cfg_events(cfg_events), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
    .pslverr(pslverr), .prdata(prdata), .busy(busy), .done(done),
    .err(err), .event_cnt(event_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // bench knobs, written only by the stimulus block
  int wait_tdr = 0;
  int rd_wait  = 0;
  int max_wait = 0;
  int err_at   = -1;
  bit noise_en = 1'b0;

  // ---------------- timer slave ----------------
  logic [7:0] tdr, tcr, tsr, tcnt, pre, snap;
  logic       rd_post, noise_q;
  int         acc_cnt, cur_wait, xcnt;
  logic [7:0] pre_lim;
  logic       step, ovf_hit, udf_hit, wr_done;
  logic [7:0] clr_m;

  assign pready  = psel && penable && (acc_cnt >= cur_wait);
  assign pslverr = pready && (xcnt == err_at);
  assign prdata  = rd_post ? snap : ~tsr;   // valid only one cycle after the read
  assign pre_lim = (8'd1 << tcr[1:0]) - 8'd1;
  assign step    = tcr[4] && (pre == pre_lim);
  assign ovf_hit = step && tcr[5] && (tcnt == 8'hFF);
  assign udf_hit = step && !tcr[5] && (tcnt == 8'h00);
  assign wr_done = psel && penable && pready && pwrite && !pslverr;
  assign clr_m   = (wr_done && paddr == 8'h02) ? pwdata : 8'h00;

  // occasional non-matching flag to prove it is ignored
  always @(posedge pclk) noise_q <= noise_en && ($urandom_range(0, 3) == 0);

  // timer registers, prescaler, status flags and wait-state insertion
  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tdr <= 8'h00; tcr <= 8'h00; tsr <= 8'h00; tcnt <= 8'h00; pre <= 8'h00;
      snap <= 8'h00; rd_post <= 1'b0; acc_cnt <= 0; cur_wait <= 0;
    end else begin
      rd_post <= psel && penable && pready && !pwrite && (paddr == 8'h02);
      snap    <= tsr;
      if (psel && !penable) begin
        acc_cnt <= 0;
        if (!pwrite && rd_wait > 0)                         cur_wait <= rd_wait;
        else if (pwrite && paddr == 8'h00 && wait_tdr > 0)  cur_wait <= wait_tdr;
        else                                                cur_wait <= int'($urandom_range(0, max_wait));
      end else if (psel && penable && !pready) begin
        acc_cnt <= acc_cnt + 1;
      end
      if (tcr[4]) pre <= step ? 8'h00 : pre + 8'd1;
      if (step) tcnt <= (ovf_hit || udf_hit) ? tdr : (tcr[5] ? tcnt + 8'd1 : tcnt - 8'd1);
      tsr <= (tsr & ~clr_m) |
             {6'b0, udf_hit | (noise_q & step & tcr[5]), ovf_hit | (noise_q & step & !tcr[5])};
      if (wr_done && paddr == 8'h00) tdr <= pwdata;
      if (wr_done && paddr == 8'h01) begin
        tcr <= {1'b0, pwdata[6:0]};
        pre <= 8'h00;
        if (pwdata[7]) tcnt <= tdr;
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] acc;
    logic [7:0] gap;
  } xfer_t;

  xfer_t      xq[$];
  int         done_cnt = 0;
  int         proto_bad = 0;
  logic [7:0] mon_acc, mon_idle, last_gap;
  logic       p_sel, p_en, p_rdy, p_wr;
  logic [7:0] p_addr, p_data;

  initial xcnt = 0;

  // transfer log, done pulse count, and APB stability / spacing checks
  always @(posedge pclk) begin
    if (!preset_n) begin
      mon_acc <= 8'd0; mon_idle <= 8'd0; last_gap <= 8'd0;
      p_sel <= 1'b0; p_en <= 1'b0; p_rdy <= 1'b0; p_wr <= 1'b0;
      p_addr <= 8'h00; p_data <= 8'h00;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (!psel) mon_idle <= (mon_idle == 8'hFF) ? 8'hFF : mon_idle + 8'd1;
      if (psel && !penable) begin
        last_gap <= mon_idle;
        mon_idle <= 8'd0;
      end
      if (psel && penable) begin
        if (pready) begin
          xq.push_back('{wr: pwrite, addr: paddr, data: pwdata, acc: mon_acc + 8'd1, gap: last_gap});
          xcnt    <= xcnt + 1;
          mon_acc <= 8'd0;
        end else begin
          mon_acc <= mon_acc + 8'd1;
        end
      end
      if (p_sel && (!p_en || !p_rdy)) begin
        if (!(psel && penable && pwrite == p_wr && paddr == p_addr && pwdata == p_data))
          proto_bad <= proto_bad + 1;
      end else if (p_sel && p_en && p_rdy && psel) begin
        proto_bad <= proto_bad + 1;
      end
      p_sel <= psel; p_en <= penable; p_rdy <= pready; p_wr <= pwrite;
      p_addr <= paddr; p_data <= pwdata;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_psel"},      32'(psel),      32'd0);
    check({pfx, "_penable"},   32'(penable),   32'd0);
    check({pfx, "_pwrite"},    32'(pwrite),    32'd0);
    check({pfx, "_paddr"},     32'(paddr),     32'd0);
    check({pfx, "_pwdata"},    32'(pwdata),    32'd0);
    check({pfx, "_busy"},      32'(busy),      32'd0);
    check({pfx, "_done"},      32'(done),      32'd0);
    check({pfx, "_err"},       32'(err),       32'd0);
    check({pfx, "_event_cnt"}, 32'(event_cnt), 32'd0);
  endtask

  task automatic run_start(input logic [7:0] d, input logic up, input logic [1:0] cks,
                           input logic [7:0] ev);
    @(negedge pclk);
    cfg_data = d; cfg_up_dw = up; cfg_cks = cks; cfg_events = ev; start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 20000) begin
      @(negedge pclk);
      k++;
    end
    check({tag, "_run_ends"}, 32'(busy), 32'd0);
  endtask

  // Expected bus activity of a complete run: setup writes, one clear per
  // event, then the stop write; polls in between are TSR reads spaced by
  // one post-transfer cycle plus POLL_GAP.
  task automatic check_normal(input string tag, input int base, input int dbase, input int pbase,
                              input logic [7:0] d, input logic up, input logic [1:0] cks,
                              input logic [7:0] ev);
    logic [15:0] exp_w[$];
    int n, nwr, reads, rd_bad, gap_bad;
    n = (ev == 8'd0) ? 1 : int'(ev);
    exp_w.push_back({8'h00, d});
    exp_w.push_back({8'h01, 8'h80 | (8'(up) << 5) | 8'(cks)});
    exp_w.push_back({8'h01, 8'h10 | (8'(up) << 5) | 8'(cks)});
    for (int i = 0; i < n; i++) exp_w.push_back({8'h02, up ? 8'h01 : 8'h02});
    exp_w.push_back(16'h0100);
    nwr = 0; reads = 0; rd_bad = 0; gap_bad = 0;
    for (int i = base; i < xq.size(); i++) begin
      if (xq[i].wr) begin
        if (nwr < exp_w.size())
          check($sformatf("%s_wr%0d", tag, nwr), 32'({xq[i].addr, xq[i].data}), 32'(exp_w[nwr]));
        nwr++;
      end else begin
        reads++;
        if (xq[i].addr != 8'h02) rd_bad++;
        if (int'(xq[i].gap) != 1 + POLL_GAP) gap_bad++;
      end
    end
    check({tag, "_n_writes"}, 32'(nwr), 32'(exp_w.size()));
    check({tag, "_reads_ok"}, 32'(reads >= n && rd_bad == 0), 32'd1);
    check({tag, "_poll_gap"}, 32'(gap_bad), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'd1);
    check({tag, "_event_cnt"}, 32'(event_cnt), 32'(n));
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_protocol"}, 32'(proto_bad - pbase), 32'd0);
  endtask

  initial begin
    int base, dbase, pbase, k, idx;
    logic [7:0] d, ev;
    logic       up;
    logic [1:0] cks;

    preset_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_data = 8'h00; cfg_up_dw = 1'b0; cfg_cks = 2'b00; cfg_events = 8'h00;
    repeat (3) @(negedge pclk);
    check_reset_outputs("rst");
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);

    // up count, two events
    base = xq.size(); dbase = done_cnt; pbase = proto_bad;
    run_start(8'hFE, 1'b1, 2'd0, 8'd2);
    wait_idle("s1");
    check_normal("s1", base, dbase, pbase, 8'hFE, 1'b1, 2'd0, 8'd2);

    // down count, events=0 treated as one, noise flags, start while busy
    noise_en = 1'b1;
    base = xq.size(); dbase = done_cnt; pbase = proto_bad;
    run_start(8'h01, 1'b0, 2'd1, 8'd0);
    repeat (8) @(negedge pclk);
    check("s2_busy_at_inject", 32'(busy), 32'd1);
    cfg_data = 8'h55; cfg_up_dw = 1'b1; cfg_events = 8'd7; start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    wait_idle("s2");
    check_normal("s2", base, dbase, pbase, 8'h01, 1'b0, 2'd1, 8'd0);
    noise_en = 1'b0;

    // slave stretches the TDR write by three wait states
    wait_tdr = 3;
    base = xq.size(); dbase = done_cnt; pbase = proto_bad;
    run_start(8'hF8, 1'b1, 2'd2, 8'd1);
    wait_idle("s3");
    check_normal("s3", base, dbase, pbase, 8'hF8, 1'b1, 2'd2, 8'd1);
    check("s3_tdr_access_cycles", 32'(xq[base].acc), 32'd4);
    wait_tdr = 0;

    // slave error on the W_RUN write
    base = xq.size(); dbase = done_cnt;
    err_at = base + 2;
    run_start(8'hF0, 1'b1, 2'd0, 8'd2);
    k = 0;
    while (xq.size() < base + 3 && k < 200) begin
      @(negedge pclk);
      k++;
    end
    check("s5_busy_after_err", 32'(busy), 32'd0);
    check("s5_err", 32'(err), 32'd1);
    err_at = -1;
    k = 0;
    repeat (20) begin
      @(negedge pclk);
      if (psel) k++;
    end
    check("s5_no_more_psel", 32'(k), 32'd0);
    check("s5_no_done", 32'(done_cnt - dbase), 32'd0);
    check("s5_n_xfers", 32'(xq.size() - base), 32'd3);

    // stop during GAP after the first event
    base = xq.size(); dbase = done_cnt; pbase = proto_bad;
    run_start(8'hF8, 1'b1, 2'd0, 8'd3);
    check("s4_err_cleared_by_start", 32'(err), 32'd0);
    idx = -1; k = 0;
    while (idx < 0 && k < 5000) begin
      @(negedge pclk);
      k++;
      for (int i = base; i < xq.size(); i++)
        if (idx < 0 && xq[i].wr && xq[i].addr == 8'h02) idx = i;
    end
    check("s4_clear_seen", 32'(idx >= 0), 32'd1);
    @(negedge pclk);
    stop = 1'b1;
    @(negedge pclk);
    stop = 1'b0;
    wait_idle("s4");
    if (idx >= 0) begin
      check("s4_n_xfers", 32'(xq.size()), 32'(idx + 2));
      if (xq.size() == idx + 2)
        check("s4_next_xfer", 32'({xq[idx + 1].wr, xq[idx + 1].addr, xq[idx + 1].data}), 32'h10100);
    end
    check("s4_no_done", 32'(done_cnt - dbase), 32'd0);
    check("s4_event_cnt", 32'(event_cnt), 32'd1);
    check("s4_protocol", 32'(proto_bad - pbase), 32'd0);

    // stop and start together in IDLE: stop wins
    base = xq.size();
    @(negedge pclk);
    start = 1'b1; stop = 1'b1;
    @(negedge pclk);
    start = 1'b0; stop = 1'b0;
    check("idle_stop_wins_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge pclk);
    check("idle_stop_wins_xfers", 32'(xq.size() - base), 32'd0);

    // reset asserted while a TSR read is in its access phase
    rd_wait = 4;
    run_start(8'hF0, 1'b1, 2'd3, 8'd5);
    k = 0;
    while (!(psel && penable && !pwrite && paddr == 8'h02) && k < 2000) begin
      @(negedge pclk);
      k++;
    end
    check("s6_in_read_access", 32'(psel && penable && !pwrite), 32'd1);
    #1 preset_n = 1'b0;
    #1 check_reset_outputs("s6");
    @(negedge pclk);
    preset_n = 1'b1;
    rd_wait = 0;
    repeat (2) @(negedge pclk);

    // randomized runs against the rule-based expectation
    max_wait = 2;
    for (int r = 0; r < 6; r++) begin
      up  = 1'($urandom_range(0, 1));
      d   = up ? (8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom_range(0, 15));
      cks = 2'($urandom_range(0, 3));
      ev  = 8'($urandom_range(0, 4));
      noise_en = 1'($urandom_range(0, 1));
      base = xq.size(); dbase = done_cnt; pbase = proto_bad;
      run_start(d, up, cks, ev);
      wait_idle($sformatf("rnd%0d", r));
      check_normal($sformatf("rnd%0d", r), base, dbase, pbase, d, up, cks, ev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
